// File: rtl/x_input_loader.sv
// ---------------------------------------------------------------------------
// x_input_loader
//
// Upstream stage of the matrix-multiply ALU. It collects a serial byte stream
// (valid/ready handshake) into four row registers, presents them to the ALU,
// rotates every row right by one element on each X_shift pulse, and releases
// the buffer for the next matrix on calc_done.
//
// Optional feature macro: LOADER_OVERRUN_EN
//   When defined, the in_overrun port exists. It is a sticky flag that is set
//   when the producer drives in_valid while the loader is holding a matrix.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_data    in   input element (BYTE_W bits)
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts an element this cycle (state == LOAD)
//   X_shift    in   one-cycle pulse: rotate all rows right by one element
//   calc_done  in   one-cycle pulse: current matrix fully consumed
//   X_reg1..4  out  row registers 0..3 (BYTE_W*ROW_BYTES bits each)
//   in_overrun out  sticky overrun flag (LOADER_OVERRUN_EN only)
//   x_valid    out  all rows loaded and stable for ALU use
//   load_cnt   out  elements accepted in the current load, 0..31
// ---------------------------------------------------------------------------
module x_input_loader #(
  parameter int BYTE_W    = 8,
  parameter int ROW_BYTES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BYTE_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        X_shift,
  input  logic                        calc_done,
  output logic [BYTE_W*ROW_BYTES-1:0] X_reg1,
  output logic [BYTE_W*ROW_BYTES-1:0] X_reg2,
  output logic [BYTE_W*ROW_BYTES-1:0] X_reg3,
  output logic [BYTE_W*ROW_BYTES-1:0] X_reg4,
`ifdef LOADER_OVERRUN_EN
  output logic                        in_overrun,
`endif
  output logic                        x_valid,
  output logic [4:0]                  load_cnt
);

  localparam int ROW_W    = BYTE_W * ROW_BYTES;
  localparam int NUM_ROWS = 4;
  localparam int LAST_IDX = NUM_ROWS * ROW_BYTES - 1;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q [NUM_ROWS];
  logic [ROW_W-1:0] row_d [NUM_ROWS];
  logic [4:0]       cnt_q, cnt_d;
  logic             x_valid_q, x_valid_d;

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int r = 0; r < NUM_ROWS; r++) begin
      row_d[r] = row_q[r];
    end

    case (state_q)
      LOAD: begin
        // X_shift and calc_done have no effect while loading.
        if (in_valid) begin
          // Element k goes to row k/ROW_BYTES, slot k%ROW_BYTES; the full
          // decode keeps every other slot untouched.
          for (int r = 0; r < NUM_ROWS; r++) begin
            for (int b = 0; b < ROW_BYTES; b++) begin
              if (cnt_q == 5'(r * ROW_BYTES + b)) begin
                row_d[r][b*BYTE_W +: BYTE_W] = in_data;
              end
            end
          end
          if (cnt_q == 5'(LAST_IDX)) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      HOLD: begin
        // A rotate coinciding with calc_done is still applied.
        if (X_shift) begin
          for (int r = 0; r < NUM_ROWS; r++) begin
            row_d[r] = {row_q[r][BYTE_W-1:0], row_q[r][ROW_W-1:BYTE_W]};
          end
        end
        if (calc_done) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    // Registered copy of "holding a complete matrix".
    x_valid_d = (state_d == HOLD);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      x_valid_q <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        row_q[r] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_valid_q <= x_valid_d;
      for (int r = 0; r < NUM_ROWS; r++) begin
        row_q[r] <= row_d[r];
      end
    end
  end

`ifdef LOADER_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Producer ignored in_ready: remember it until reset. The element itself is
  // already dropped because HOLD never writes the rows from in_data.
  always_comb begin
    overrun_d = overrun_q | ((state_q == HOLD) & in_valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign in_overrun = overrun_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready = (state_q == LOAD);
  assign x_valid  = x_valid_q;
  assign load_cnt = cnt_q;
  assign X_reg1   = row_q[0];
  assign X_reg2   = row_q[1];
  assign X_reg3   = row_q[2];
  assign X_reg4   = row_q[3];

endmodule

// File: tb/tb_x_input_loader.sv
// ---------------------------------------------------------------------------
// tb_x_input_loader
//
// Self-checking bench for x_input_loader. A behavioural model holds the
// matrix as a 4x8 array of bytes plus a load counter and a hold flag; every
// clock edge the bench applies the same inputs to the model and the DUT.
// Define LOADER_OVERRUN_EN for both files to cover the overrun flag.
// ---------------------------------------------------------------------------
module tb_x_input_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        X_shift;
  logic        calc_done;
  logic [63:0] X_reg1, X_reg2, X_reg3, X_reg4;
  logic        x_valid;
  logic [4:0]  load_cnt;
`ifdef LOADER_OVERRUN_EN
  logic        in_overrun;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  x_input_loader #(.BYTE_W(8), .ROW_BYTES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X_shift   (X_shift),
    .calc_done (calc_done),
    .X_reg1    (X_reg1),
    .X_reg2    (X_reg2),
    .X_reg3    (X_reg3),
    .X_reg4    (X_reg4),
`ifdef LOADER_OVERRUN_EN
    .in_overrun(in_overrun),
`endif
    .x_valid   (x_valid),
    .load_cnt  (load_cnt)
  );

  // ---------------- behavioural model ----------------
  logic [7:0] m_b [4][8];
  int         m_cnt;
  bit         m_hold;
  bit         m_ovr;

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 8; j++) m_b[r][j] = 8'h00;
    m_cnt  = 0;
    m_hold = 0;
    m_ovr  = 0;
  endtask

  task automatic model_edge();
    logic [7:0] t;
    if (!m_hold) begin
      if (in_valid) begin
        m_b[m_cnt / 8][m_cnt % 8] = in_data;
        m_cnt = m_cnt + 1;
        if (m_cnt == 32) begin
          m_cnt  = 0;
          m_hold = 1;
        end
      end
    end else begin
      if (in_valid) m_ovr = 1;
      if (X_shift) begin
        for (int r = 0; r < 4; r++) begin
          t = m_b[r][0];
          for (int j = 0; j < 7; j++) m_b[r][j] = m_b[r][j+1];
          m_b[r][7] = t;
        end
      end
      if (calc_done) m_hold = 0;
    end
  endtask

  function automatic logic [63:0] exp_row(int r);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[8*j +: 8] = m_b[r][j];
    return v;
  endfunction

  function automatic logic [63:0] dut_row(int r);
    case (r)
      0:       return X_reg1;
      1:       return X_reg2;
      2:       return X_reg3;
      default: return X_reg4;
    endcase
  endfunction

  // One clock: drive inputs, advance model at the edge, sample 1 ns later.
  task automatic cyc(input bit v, input logic [7:0] d, input bit sh, input bit cd);
    in_valid  = v;
    in_data   = d;
    X_shift   = sh;
    calc_done = cd;
    @(posedge clk);
    model_edge();
    #1;
    in_valid  = 1'b0;
    X_shift   = 1'b0;
    calc_done = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    in_valid = 0; in_data = 0; X_shift = 0; calc_done = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut_row(r) !== 64'h0) begin
        errors++; $display("FAIL reset_row%0d got %h exp 0", r, dut_row(r));
      end
    end
    checks++;
    if (load_cnt !== 5'd0 || x_valid !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_valid got cnt=%0d xv=%b exp 0/0", load_cnt, x_valid);
    end
`ifdef LOADER_OVERRUN_EN
    checks++;
    if (in_overrun !== 1'b0) begin
      errors++; $display("FAIL reset_overrun got %b exp 0", in_overrun);
    end
`endif
    rst = 1'b1;
    cyc(0, 8'h00, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    for (int k = 0; k < 32; k++) begin
      if (k == 31) begin
        checks++;
        if (x_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++; $display("FAIL stream_before_last got xv=%b rdy=%b exp 0/1", x_valid, in_ready);
        end
      end
      cyc(1, 8'(k), 0, 0);
    end
    checks++;
    if (X_reg1 !== 64'h0706050403020100) begin
      errors++; $display("FAIL stream_x1 got %h exp 0706050403020100", X_reg1);
    end
    checks++;
    if (X_reg4 !== 64'h1F1E1D1C1B1A1918) begin
      errors++; $display("FAIL stream_x4 got %h exp 1f1e1d1c1b1a1918", X_reg4);
    end
    for (int r = 1; r < 3; r++) begin
      checks++;
      if (dut_row(r) !== exp_row(r)) begin
        errors++; $display("FAIL stream_row%0d got %h exp %h", r, dut_row(r), exp_row(r));
      end
    end
    checks++;
    if (x_valid !== 1'b1 || in_ready !== 1'b0 || load_cnt !== 5'd0) begin
      errors++; $display("FAIL stream_hold got xv=%b rdy=%b cnt=%0d exp 1/0/0", x_valid, in_ready, load_cnt);
    end
    $display("test_stream done");
  endtask

  task automatic test_shift();
    cyc(0, 8'h00, 1, 0);
    checks++;
    if (X_reg1 !== 64'h0007060504030201) begin
      errors++; $display("FAIL shift1_x1 got %h exp 0007060504030201", X_reg1);
    end
    repeat (7) cyc(0, 8'h00, 1, 0);
    checks++;
    if (X_reg1 !== 64'h0706050403020100) begin
      errors++; $display("FAIL shift8_x1 got %h exp 0706050403020100", X_reg1);
    end
    checks++;
    if (X_reg4 !== 64'h1F1E1D1C1B1A1918 || x_valid !== 1'b1) begin
      errors++; $display("FAIL shift8_x4 got %h xv=%b exp 1f1e1d1c1b1a1918/1", X_reg4, x_valid);
    end
    $display("test_shift done");
  endtask

  task automatic test_shift_done();
    cyc(0, 8'h00, 1, 1);
    checks++;
    if (X_reg1 !== 64'h0007060504030201) begin
      errors++; $display("FAIL shiftdone_x1 got %h exp 0007060504030201", X_reg1);
    end
    checks++;
    if (x_valid !== 1'b0 || load_cnt !== 5'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL shiftdone_ctl got xv=%b cnt=%0d rdy=%b exp 0/0/1", x_valid, load_cnt, in_ready);
    end
    cyc(1, 8'hAA, 0, 0);
    checks++;
    if (X_reg1 !== 64'h00070605040302AA) begin
      errors++; $display("FAIL shiftdone_aa got %h exp 00070605040302aa", X_reg1);
    end
    for (int k = 1; k < 32; k++) cyc(1, 8'($urandom), 0, 0);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut_row(r) !== exp_row(r)) begin
        errors++; $display("FAIL reload_row%0d got %h exp %h", r, dut_row(r), exp_row(r));
      end
    end
    cyc(0, 8'h00, 0, 1);
    $display("test_shift_done done");
  endtask

  task automatic test_gaps();
    int  sent = 0;
    int  cycles = 0;
    logic [63:0] e;
    while (sent < 32 && cycles < 500) begin
      bit v = ($urandom % 2) == 1;
      cyc(v, 8'(8'h80 + sent), 0, 0);
      if (v) sent++;
      cycles++;
      checks++;
      if (int'(load_cnt) !== m_cnt) begin
        errors++; $display("FAIL gaps_cnt got %0d exp %0d", load_cnt, m_cnt);
      end
    end
    checks++;
    if (sent != 32 || x_valid !== 1'b1) begin
      errors++; $display("FAIL gaps_done got sent=%0d xv=%b exp 32/1", sent, x_valid);
    end
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 8; j++) e[8*j +: 8] = 8'(8'h80 + 8*r + j);
      checks++;
      if (dut_row(r) !== e) begin
        errors++; $display("FAIL gaps_row%0d got %h exp %h", r, dut_row(r), e);
      end
    end
    cyc(0, 8'h00, 0, 1);
    $display("test_gaps done");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 13; k++) cyc(1, 8'($urandom), 0, 0);
    rst = 1'b0;
    #2;
    model_reset();
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut_row(r) !== 64'h0) begin
        errors++; $display("FAIL midreset_row%0d got %h exp 0", r, dut_row(r));
      end
    end
    checks++;
    if (load_cnt !== 5'd0 || x_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_ctl got cnt=%0d xv=%b exp 0/0", load_cnt, x_valid);
    end
    #3;
    rst = 1'b1;
    for (int k = 0; k < 32; k++) cyc(1, 8'($urandom), 0, 0);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut_row(r) !== exp_row(r)) begin
        errors++; $display("FAIL postreset_row%0d got %h exp %h", r, dut_row(r), exp_row(r));
      end
    end
    checks++;
    if (x_valid !== 1'b1) begin
      errors++; $display("FAIL postreset_xv got %b exp 1", x_valid);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_hold_input();
    cyc(1, 8'h55, 0, 0);
    cyc(1, 8'h55, 0, 0);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut_row(r) !== exp_row(r)) begin
        errors++; $display("FAIL holdin_row%0d got %h exp %h", r, dut_row(r), exp_row(r));
      end
    end
    checks++;
    if (load_cnt !== 5'd0 || x_valid !== 1'b1) begin
      errors++; $display("FAIL holdin_ctl got cnt=%0d xv=%b exp 0/1", load_cnt, x_valid);
    end
`ifdef LOADER_OVERRUN_EN
    checks++;
    if (in_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set got %b exp 1", in_overrun);
    end
`endif
    cyc(0, 8'h00, 0, 1);
`ifdef LOADER_OVERRUN_EN
    checks++;
    if (in_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky got %b exp 1", in_overrun);
    end
`endif
    checks++;
    if (x_valid !== 1'b0) begin
      errors++; $display("FAIL holdin_release got %b exp 0", x_valid);
    end
    $display("test_hold_input done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit v  = ($urandom % 4) != 0;
      bit sh = ($urandom % 3) == 0;
      bit cd = ($urandom % 12) == 0;
      cyc(v, 8'($urandom), sh, cd);
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (dut_row(r) !== exp_row(r)) begin
          errors++; $display("FAIL rand_row%0d cyc %0d got %h exp %h", r, i, dut_row(r), exp_row(r));
        end
      end
      checks++;
      if (int'(load_cnt) !== m_cnt || x_valid !== m_hold || in_ready !== !m_hold) begin
        errors++;
        $display("FAIL rand_ctl cyc %0d got cnt=%0d xv=%b rdy=%b exp %0d/%b/%b",
                 i, load_cnt, x_valid, in_ready, m_cnt, m_hold, !m_hold);
      end
`ifdef LOADER_OVERRUN_EN
      checks++;
      if (in_overrun !== m_ovr) begin
        errors++; $display("FAIL rand_overrun cyc %0d got %b exp %b", i, in_overrun, m_ovr);
      end
`endif
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_shift();
    test_shift_done();
    test_gaps();
    test_reset_mid();
    test_hold_input();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/x_input_loader.md
Name: x_input_loader

Overview:
- Upstream stage of the matrix-multiply ALU.
- Accepts a serial byte stream over a valid/ready handshake and packs 32 bytes into four 64-bit row registers, X_reg1..X_reg4.
- Presents the rows to the ALU, rotates them one byte per X_shift pulse from the ALU, and releases the buffer for the next load when the ALU signals calc_done.

Parameters:
- BYTE_W, 8, width of one input element in bits.
- ROW_BYTES, 8, elements per row register; row width = BYTE_W*ROW_BYTES (64).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  BYTE_W  input element.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- X_shift  input  1  one-cycle pulse from ALU: rotate all rows by one byte.
- calc_done  input  1  one-cycle pulse from ALU: current matrix fully consumed.
- X_reg1  output  64  row 0.
- X_reg2  output  64  row 1.
- X_reg3  output  64  row 2.
- X_reg4  output  64  row 3.
- x_valid  output  1  all four rows loaded and stable for ALU use.
- load_cnt  output  5  bytes accepted in the current load, 0..31.
- in_overrun  output  1  sticky error flag; present only with the optional feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD, X_reg1..4=0, load_cnt=0, x_valid=0, in_overrun=0.
  - in_ready=1 from the first clock edge after reset release.
  - Reset mid-load or mid-hold discards all contents.
- States: LOAD and HOLD, 1-bit state register. All outputs are registered except in_ready, which is (state==LOAD).
- LOAD:
  - A byte is accepted on a clock edge with in_valid & in_ready.
  - Byte k (k=load_cnt) is written into row k/8, bit field [8*(k%8)+7 : 8*(k%8)]; other bits are unchanged. load_cnt increments.
  - On accepting byte 31: load_cnt wraps to 0, state->HOLD, and x_valid=1 from the next cycle. Latency from the last accept to x_valid is 1 cycle.
  - in_valid=0 stalls with no change.
  - X_shift and calc_done are ignored in LOAD.
- HOLD:
  - in_ready=0; input bytes are not accepted.
  - X_shift=1: every row rotates right by one byte, i.e. X_reg <= {X_reg[7:0], X_reg[63:8]}. All four rows rotate in the same cycle. After 8 shifts the contents equal the loaded values.
  - calc_done=1: state->LOAD and x_valid=0 next cycle; row contents are retained until overwritten.
  - X_shift and calc_done in the same cycle: the rotate is applied and the state returns to LOAD.
- Back-to-back loads: the first byte of the next matrix can be accepted in the cycle after calc_done, so the minimum period is 32 load cycles + ALU cycles + 1.
- Row registers are never partially visible as valid: x_valid=0 throughout LOAD.

Optional Feature:
- Macro: LOADER_OVERRUN_EN.
- Defined:
  - in_overrun port exists.
  - It is set to 1 on any clock edge with state==HOLD and in_valid=1, i.e. the producer ignored in_ready.
  - It stays sticky until reset; the data byte is dropped and the rows are unchanged.
- Not defined:
  - in_overrun port and logic are absent.
  - in_valid during HOLD is silently ignored. All other behaviour is identical.

Test Plan:
- Reset, then stream bytes 0x00..0x1F with in_valid held high:
  - X_reg1=64'h0706050403020100, X_reg4=64'h1F1E1D1C1B1A1918.
  - x_valid=1 exactly one cycle after byte 0x1F is accepted; in_ready=0 in HOLD.
- From HOLD after the above, one X_shift pulse:
  - X_reg1=64'h0007060504030201.
  - 8 pulses restore X_reg1=64'h0706050403020100; x_valid stays 1.
- Simultaneous X_shift and calc_done in HOLD:
  - Rows rotated once, x_valid=0 next cycle, load_cnt=0, in_ready=1.
  - The next byte 0xAA lands in X_reg1[7:0].
- Random in_valid gaps during a load of 0x80..0x9F:
  - Final rows identical to the gap-free case; load_cnt tracks accepted bytes only.
- Assert rst low after 13 bytes, then release:
  - All rows 0, load_cnt=0, x_valid=0.
  - A new 32-byte load completes normally.
- With LOADER_OVERRUN_EN, in_valid=1 with in_data=0x55 during HOLD:
  - in_overrun=1 next cycle and stays 1 through calc_done; rows unchanged.
  - Without the macro, rows are unchanged and no port exists.
